// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcode/func values, datapath mux codes and the decoded instruction class.
package mc_defs;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        MDWAIT = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd3;

    localparam logic [1:0] EXT_SIGN      = 2'd0;
    localparam logic [1:0] EXT_ZERO      = 2'd1;
    localparam logic [1:0] EXT_SIGN_SHL2 = 2'd2;
    localparam logic [1:0] EXT_HIGH      = 2'd3;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_REG    = 2'd3;

    localparam logic [1:0] M2R_DM   = 2'd0;
    localparam logic [1:0] M2R_ALU  = 2'd1;
    localparam logic [1:0] M2R_PC   = 2'd2;
    localparam logic [1:0] M2R_HILO = 2'd3;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Exactly one field is set for any instruction word.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic mult;
        logic multu;
        logic div;
        logic divu;
        logic mfhi;
        logic mflo;
        logic illegal;
    } instrClass_t;

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: IR word -> one-hot instruction class
// plus the datapath mux controls, which are independent of FSM state.
module mc_decode
    import mc_defs::*;
(
    input  logic [31:0]  instr,
    output instrClass_t  cls,
    output logic [1:0]   extOp,
    output logic [2:0]   aluOp,
    output logic         aluB,
    output logic [1:0]   memToReg,
    output logic         hiLoSel,
    output logic [1:0]   mdOp,
    output logic [4:0]   grfWriteAddr
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unusedBits;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign unusedBits = ^{instr[25:21], instr[10:6]};

    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU:  cls.addu  = 1'b1;
                    FN_SUBU:  cls.subu  = 1'b1;
                    FN_JR:    cls.jr    = 1'b1;
                    FN_MULT:  cls.mult  = 1'b1;
                    FN_MULTU: cls.multu = 1'b1;
                    FN_DIV:   cls.div   = 1'b1;
                    FN_DIVU:  cls.divu  = 1'b1;
                    FN_MFHI:  cls.mfhi  = 1'b1;
                    FN_MFLO:  cls.mflo  = 1'b1;
                    default:  cls.illegal = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

    always_comb begin
        extOp        = EXT_SIGN;
        aluOp        = ALU_ADD;
        aluB         = 1'b0;
        memToReg     = M2R_ALU;
        hiLoSel      = cls.mfhi;
        mdOp         = MD_MULT;
        grfWriteAddr = 5'd0;

        if (cls.ori)      extOp = EXT_ZERO;
        else if (cls.lui) extOp = EXT_HIGH;
        else if (cls.beq) extOp = EXT_SIGN_SHL2;

        if (cls.subu || cls.beq) aluOp = ALU_SUB;
        else if (cls.ori)        aluOp = ALU_OR;

        // lui adds the shifted immediate to $0, so it also takes the EXT path.
        aluB = cls.ori | cls.lui | cls.lw | cls.sw;

        if (cls.lw)                    memToReg = M2R_DM;
        else if (cls.mfhi | cls.mflo)  memToReg = M2R_HILO;
        else if (cls.jal)              memToReg = M2R_PC;

        if (cls.multu)     mdOp = MD_MULTU;
        else if (cls.div)  mdOp = MD_DIV;
        else if (cls.divu) mdOp = MD_DIVU;

        if (cls.addu | cls.subu | cls.mfhi | cls.mflo) grfWriteAddr = rd;
        else if (cls.ori | cls.lw | cls.lui)          grfWriteAddr = rt;
        else if (cls.jal)                             grfWriteAddr = 5'd31;
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing PC, IR, GRF, ALU, DM
// and the mult/div unit, with a shared down-counter for MEM and MDWAIT timing.
//
//  state  | meaning
//  FETCH  | load IR, PC <= PC+4
//  DECODE | resolve j/jal/jr, flag illegal words
//  EXEC   | ALU op, branch resolve, mult/div launch
//  MEM    | DM access after MEM_WAIT wait cycles
//  WB     | register file write
//  MDWAIT | hold while mult/div unit computes
module mc_ctrl_fsm
    import mc_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int MEM_WAIT    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        pcWE,
    output logic [1:0]  npcSel,
    output logic        irWE,
    output logic        grfWE,
    output logic [4:0]  grfWriteAddr,
    output logic [1:0]  extOp,
    output logic [2:0]  aluOp,
    output logic        aluB,
    output logic [1:0]  memToReg,
    output logic        hiLoSel,
    output logic        dmWE,
    output logic        mdStart,
    output logic [1:0]  mdOp,
    output logic        busy,
    output logic        illegal
);

    localparam int CNT_W = $clog2(maxOf3(MULT_CYCLES, DIV_CYCLES, MEM_WAIT) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD  = CNT_W'(MEM_WAIT);

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    instrClass_t      cls;
    logic             aluClass;
    logic             mdClass;

    mc_decode uDecode (
        .instr        (instr),
        .cls          (cls),
        .extOp        (extOp),
        .aluOp        (aluOp),
        .aluB         (aluB),
        .memToReg     (memToReg),
        .hiLoSel      (hiLoSel),
        .mdOp         (mdOp),
        .grfWriteAddr (grfWriteAddr)
    );

    assign aluClass = cls.addu | cls.subu | cls.ori | cls.lui | cls.mfhi | cls.mflo;
    assign mdClass  = cls.mult | cls.multu | cls.div | cls.divu;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        pcWE      = 1'b0;
        npcSel    = NPC_PC4;
        irWE      = 1'b0;
        grfWE     = 1'b0;
        dmWE      = 1'b0;
        mdStart   = 1'b0;
        busy      = 1'b0;
        illegal   = 1'b0;

        case (state)
            FETCH: begin
                irWE      = 1'b1;
                pcWE      = 1'b1;
                stateNext = DECODE;
            end
            DECODE: begin
                stateNext = FETCH;
                if (cls.j || cls.jal) begin
                    pcWE   = 1'b1;
                    npcSel = NPC_JUMP;
                    grfWE  = cls.jal;
                end else if (cls.jr) begin
                    pcWE   = 1'b1;
                    npcSel = NPC_REG;
                end else if (cls.illegal) begin
                    illegal = 1'b1;
                end else begin
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                stateNext = FETCH;
                if (cls.lw || cls.sw) begin
                    cntNext   = MEM_LOAD;
                    stateNext = MEM;
                end else if (cls.beq) begin
                    pcWE   = zero;
                    npcSel = NPC_BRANCH;
                end else if (mdClass) begin
                    mdStart   = 1'b1;
                    cntNext   = (cls.mult || cls.multu) ? MULT_LOAD : DIV_LOAD;
                    stateNext = MDWAIT;
                end else if (aluClass) begin
                    stateNext = WB;
                end
            end
            MEM: begin
                if (cnt != '0) begin
                    busy    = 1'b1;
                    cntNext = cnt - 1'b1;
                end else if (cls.sw) begin
                    dmWE      = 1'b1;
                    stateNext = FETCH;
                end else begin
                    stateNext = WB;
                end
            end
            WB: begin
                grfWE     = 1'b1;
                stateNext = FETCH;
            end
            MDWAIT: begin
                busy = 1'b1;
                if (cnt == '0) stateNext = FETCH;
                else           cntNext   = cnt - 1'b1;
            end
            default: stateNext = FETCH;
        endcase

        // Enables must stay quiet while reset is held, whatever state we left.
        if (reset) begin
            pcWE    = 1'b0;
            irWE    = 1'b0;
            grfWE   = 1'b0;
            dmWE    = 1'b0;
            mdStart = 1'b0;
            busy    = 1'b0;
            illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: a per-instruction cycle-schedule model
// checked every cycle, plus literal expectations on observed event counts.
module tb_mc_ctrl_fsm;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 3;
    localparam int MW     = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        pcWE, irWE, grfWE, aluB, hiLoSel, dmWE, mdStart, busy, illegal;
    logic [1:0]  npcSel, extOp, memToReg, mdOp;
    logic [2:0]  aluOp;
    logic [4:0]  grfWriteAddr;

    mc_ctrl_fsm #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .MEM_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero),
        .pcWE(pcWE), .npcSel(npcSel), .irWE(irWE), .grfWE(grfWE),
        .grfWriteAddr(grfWriteAddr), .extOp(extOp), .aluOp(aluOp), .aluB(aluB),
        .memToReg(memToReg), .hiLoSel(hiLoSel), .dmWE(dmWE), .mdStart(mdStart),
        .mdOp(mdOp), .busy(busy), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcWE;
        logic [1:0] npcSel;
        logic       irWE;
        logic       grfWE;
        logic [4:0] addr;
        logic [1:0] extOp;
        logic [2:0] aluOp;
        logic       aluB;
        logic [1:0] memToReg;
        logic       hiLoSel;
        logic       dmWE;
        logic       mdStart;
        logic [1:0] mdOp;
        logic       busy;
        logic       illegal;
    } exp_t;

    typedef enum {cADDU, cSUBU, cORI, cLUI, cLW, cSW, cBEQ, cJ, cJAL, cJR,
                  cMULT, cMULTU, cDIV, cDIVU, cMFHI, cMFLO, cILL} cls_t;

    function automatic cls_t classify(input logic [31:0] w);
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h21: return cADDU;
                6'h23: return cSUBU;
                6'h08: return cJR;
                6'h18: return cMULT;
                6'h19: return cMULTU;
                6'h1A: return cDIV;
                6'h1B: return cDIVU;
                6'h10: return cMFHI;
                6'h12: return cMFLO;
                default: return cILL;
            endcase
            6'h0D: return cORI;
            6'h0F: return cLUI;
            6'h23: return cLW;
            6'h2B: return cSW;
            6'h04: return cBEQ;
            6'h02: return cJ;
            6'h03: return cJAL;
            default: return cILL;
        endcase
    endfunction

    function automatic int cycles(input cls_t c);
        case (c)
            cJ, cJAL, cJR, cILL:          return 2;
            cBEQ:                         return 3;
            cSW:                          return 4 + MW;
            cLW:                          return 5 + MW;
            cMULT, cMULTU:                return 3 + MULT_N;
            cDIV, cDIVU:                  return 3 + DIV_N;
            default:                      return 4;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = fetch) of instruction w.
    function automatic exp_t model(input logic [31:0] w, input logic z, input int k);
        exp_t e;
        cls_t c;
        bit   isMd, isMem;
        c = classify(w);
        e = '0;
        isMd  = (c == cMULT) || (c == cMULTU) || (c == cDIV) || (c == cDIVU);
        isMem = (c == cLW) || (c == cSW);
        e.extOp    = (c == cORI) ? 2'd1 : (c == cLUI) ? 2'd3 : (c == cBEQ) ? 2'd2 : 2'd0;
        e.aluOp    = (c == cSUBU || c == cBEQ) ? 3'd1 : (c == cORI) ? 3'd3 : 3'd0;
        e.aluB     = (c == cORI) || (c == cLUI) || isMem;
        e.memToReg = (c == cLW) ? 2'd0 : (c == cMFHI || c == cMFLO) ? 2'd3 : (c == cJAL) ? 2'd2 : 2'd1;
        e.hiLoSel  = (c == cMFHI);
        e.mdOp     = (c == cMULTU) ? 2'd1 : (c == cDIV) ? 2'd2 : (c == cDIVU) ? 2'd3 : 2'd0;
        if (c == cADDU || c == cSUBU || c == cMFHI || c == cMFLO) e.addr = w[15:11];
        else if (c == cORI || c == cLW || c == cLUI)               e.addr = w[20:16];
        else if (c == cJAL)                                        e.addr = 5'd31;
        if (k == 0) begin
            e.irWE = 1'b1;
            e.pcWE = 1'b1;
        end else if (k == 1) begin
            if (c == cJ || c == cJAL) begin
                e.pcWE = 1'b1; e.npcSel = 2'd2; e.grfWE = (c == cJAL);
            end else if (c == cJR) begin
                e.pcWE = 1'b1; e.npcSel = 2'd3;
            end else if (c == cILL) begin
                e.illegal = 1'b1;
            end
        end else if (k == 2) begin
            if (c == cBEQ) begin
                e.pcWE = z; e.npcSel = 2'd1;
            end else if (isMd) begin
                e.mdStart = 1'b1;
            end
        end else begin
            if (isMd)              e.busy = 1'b1;
            else if (isMem) begin
                if (k < 3 + MW)       e.busy = 1'b1;
                else if (k == 3 + MW) e.dmWE = (c == cSW);
                else                  e.grfWE = 1'b1;
            end else               e.grfWE = 1'b1;
        end
        return e;
    endfunction

    int    nCompared = 0;
    int    nMismatched = 0;
    int    mode = 0;        // 0 idle, 1 reset check, 2 model check, 3 literal check
    int    curK = 0;
    string curTag = "";
    exp_t  expRec;
    string litName = "";
    int    litAct = 0;
    int    litExp = 0;
    int    obsPc = 0, obsGrf = 0, obsBusy = 0, obsMd = 0, obsIll = 0, obsDm = 0;
    int    lastAddr = 0, lastM2R = 0, lastMdOp = 0;

    always @(negedge clk) begin
        exp_t a;
        if (mode == 1) begin
            nCompared++;
            if ({pcWE, irWE, grfWE, dmWE, mdStart, illegal} !== 6'b0) begin
                nMismatched++;
                $display("FAIL reset_enables: got pc/ir/grf/dm/md/ill=%b want 000000",
                         {pcWE, irWE, grfWE, dmWE, mdStart, illegal});
            end
        end else if (mode == 2) begin
            a = '{pcWE, npcSel, irWE, grfWE, grfWriteAddr, extOp, aluOp, aluB,
                  memToReg, hiLoSel, dmWE, mdStart, mdOp, busy, illegal};
            if (!expRec.pcWE)  a.npcSel = expRec.npcSel;
            if (!expRec.grfWE) a.addr   = expRec.addr;
            nCompared++;
            if (a !== expRec) begin
                nMismatched++;
                $display("FAIL cycle_%s k=%0d: got %h want %h", curTag, curK, a, expRec);
            end
            if (pcWE)    obsPc++;
            if (busy)    obsBusy++;
            if (illegal) obsIll++;
            if (dmWE)    obsDm++;
            if (mdStart) begin obsMd++; lastMdOp = int'(mdOp); end
            if (grfWE) begin
                obsGrf++;
                lastAddr = int'(grfWriteAddr);
                lastM2R  = int'(memToReg);
            end
        end else if (mode == 3) begin
            nCompared++;
            if (litAct != litExp) begin
                nMismatched++;
                $display("FAIL %s: got %0d want %0d", litName, litAct, litExp);
            end
        end
    end

    task automatic runCycles(input logic [31:0] w, input logic z, input string tag, input int kEnd);
        instr  = w;
        zero   = z;
        curTag = tag;
        for (int k = 0; k < kEnd; k++) begin
            curK   = k;
            expRec = model(w, z, k);
            mode   = 2;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runInstr(input logic [31:0] w, input logic z, input string tag);
        runCycles(w, z, tag, cycles(classify(w)));
    endtask

    task automatic resetCycle();
        reset = 1'b1;
        mode  = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mode  = 0;
    endtask

    // Literal checks run with the DUT parked in reset so it stays at FETCH.
    task automatic lit(input string name, input int act, input int expv);
        reset   = 1'b1;
        litName = name;
        litAct  = act;
        litExp  = expv;
        mode    = 3;
        @(negedge clk);
        @(posedge clk);
        #1;
        mode  = 0;
        reset = 1'b0;
    endtask

    int sPc, sGrf, sBusy, sMd, sIll, sDm;
    task automatic snap();
        sPc = obsPc; sGrf = obsGrf; sBusy = obsBusy; sMd = obsMd; sIll = obsIll; sDm = obsDm;
    endtask

    initial begin
        mode = 1;
        repeat (2) begin
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        mode  = 0;

        snap(); runInstr(32'h00221821, 1'b0, "addu");
        lit("addu_grf_count", obsGrf - sGrf, 1);
        lit("addu_grf_addr", lastAddr, 3);
        lit("addu_mem_to_reg", lastM2R, 1);

        snap(); runInstr(32'h8C040008, 1'b0, "lw");
        lit("lw_busy_cycles", obsBusy - sBusy, 2);
        lit("lw_grf_addr", lastAddr, 4);
        lit("lw_mem_to_reg", lastM2R, 0);

        snap(); runInstr(32'h10210001, 1'b1, "beq_taken");
        lit("beq_taken_pc_writes", obsPc - sPc, 2);
        snap(); runInstr(32'h10210001, 1'b0, "beq_not_taken");
        lit("beq_not_taken_pc_writes", obsPc - sPc, 1);

        snap(); runInstr(32'h00220018, 1'b0, "mult");
        lit("mult_start_pulses", obsMd - sMd, 1);
        lit("mult_busy_cycles", obsBusy - sBusy, 5);
        lit("mult_md_op", lastMdOp, 0);

        snap(); runInstr(32'h0C000010, 1'b0, "jal");
        lit("jal_grf_addr", lastAddr, 31);
        lit("jal_mem_to_reg", lastM2R, 2);
        lit("jal_pc_writes", obsPc - sPc, 2);

        snap(); runInstr(32'hFC000000, 1'b0, "illegal_op");
        runInstr(32'h00000000, 1'b0, "illegal_func");
        lit("illegal_pulses", obsIll - sIll, 2);
        lit("illegal_grf_writes", obsGrf - sGrf, 0);

        runInstr(32'h00221823, 1'b0, "subu");
        runInstr(32'h3423ABCD, 1'b0, "ori");
        runInstr(32'h3C05FFFF, 1'b0, "lui");
        runInstr(32'hAC040008, 1'b0, "sw");
        runInstr(32'h08000010, 1'b0, "j");
        runInstr(32'h03E00008, 1'b0, "jr");
        runInstr(32'h00220019, 1'b0, "multu");
        runInstr(32'h0022001A, 1'b0, "div");
        runInstr(32'h0022001B, 1'b0, "divu");
        runInstr(32'h00001810, 1'b0, "mfhi");
        runInstr(32'h00002012, 1'b0, "mflo");

        runCycles(32'h00220018, 1'b0, "mult_abort", 5);
        resetCycle();
        runInstr(32'h00221821, 1'b0, "addu_after_md_abort");

        snap(); runCycles(32'hAC040008, 1'b0, "sw_abort", 4);
        resetCycle();
        runInstr(32'h3423ABCD, 1'b0, "ori_after_mem_abort");
        lit("sw_abort_dm_writes", obsDm - sDm, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
